irqctrl: RTL and testbench
==========================

IRQCTRL -- requirements
Module: irqctrl

Interface
REQ-001 NUM_SRC, 8, number of interrupt sources; fixed at 8 in this revision.
REQ-002 clk  input  1  system clock, same as the CPU clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 src  input  8  peripheral interrupt requests, active-high: bit0 vpu, bit1 simpleio, bit2 uartio, bits7:3 spare (tie 0).
REQ-005 AD  input  3  register select.
REQ-006 DI  input  8  CPU write data.
REQ-007 DO  output  8  read data, combinational from registers.
REQ-008 rw  input  1  1=read, 0=write.
REQ-009 cs  input  1  block select, already qualified by VMA; decoded at $E620.
REQ-010 irq  output  1  registered interrupt request to the CPU, active-high.

Function
REQ-011 Registers by AD: 0 PEND, 1 MASK, 2 EDGE, 3 VECT (read-only), 4 CTRL (bit0 = GIE, bits7:1 read 0), 5 RAW (read-only); AD 6-7 read 8'h00, writes ignored.
REQ-012 Write strobe is cs && !rw; the register updates on that rising clk edge.
REQ-013 Reads have no side effects.
REQ-014 src_s is the sampled source vector (see REQ-025/026); RAW reads src_s.
REQ-015 Level mode (EDGE[i]=0): PEND[i] <= src_s[i] every cycle; PEND writes are ignored for that bit.
REQ-016 Edge mode (EDGE[i]=1): PEND[i] sets on a 0->1 transition of src_s[i] (versus the previous-cycle register src_d[i]).
REQ-017 Edge-mode PEND[i] clears only by writing 1 to PEND bit i (write-1-to-clear); writing 0 has no effect.
REQ-018 If a set event and a W1C hit the same bit in the same cycle, set wins and the bit stays 1.
REQ-019 Writing EDGE clears PEND bits whose mode changes in that cycle; unchanged bits keep their value.
REQ-020 Active vector act = PEND & MASK.
REQ-021 irq <= GIE && |act, i.e. one clk after act/GIE change.
REQ-022 VECT reads {5'b0, idx} for the lowest-indexed set bit of act (bit0 has the highest priority); reads 8'h80 when act == 0.
REQ-023 Deasserting GIE or MASK drops irq the next cycle; PEND is preserved.

Reset
REQ-024 While rst=0: PEND, MASK, EDGE, CTRL, src_d, synchroniser flops = 0; irq = 0; on release, first update at the next rising clk edge.

Configuration
REQ-025 IRQCTRL_SYNC_EN defined: src passes through a 2-flop synchroniser before src_s, giving src -> PEND latency of 3 edges and src -> irq of 4.
REQ-026 IRQCTRL_SYNC_EN undefined: src_s = src directly, giving src -> PEND latency of 1 edge and src -> irq of 2.

Structure
REQ-027 Shared package p601_irq_pkg holds NUM_SRC, the register offsets (PEND=0, MASK=1, EDGE=2, VECT=3, CTRL=4, RAW=5), VECT_NONE=8'h80 and the source bit assignments.
REQ-028 The single sub-module irq_prio_enc is an 8-bit lowest-index priority encoder: outputs idx[2:0] and valid.
REQ-029 The top level replaces the cpu_irq OR with irqctrl.irq.

Verification (no sync unless stated)
REQ-030 Reset, then MASK=8'h02, CTRL=1, src[1] high for 5 cycles (level mode) -> irq=1 two edges after rise, 0 two edges after fall; VECT=8'h01 while high.
REQ-031 EDGE=8'h04, MASK=8'h04, GIE=1, one-cycle pulse on src[2] -> PEND=8'h04 held and irq held; write PEND=8'h04 -> PEND=0, irq=0 the next edge.
REQ-032 src[2] rising edge in the same cycle as a W1C of bit 2 -> PEND[2] stays 1.
REQ-033 act=8'h0A -> VECT=8'h01; clear bit1 -> VECT=8'h03; act=0 -> VECT=8'h80.
REQ-034 rst asserted with PEND=8'hFF and irq=1 -> all registers and irq read 0 immediately, without waiting for a clk edge.
REQ-035 IRQCTRL_SYNC_EN defined, src[0] rises (level mode, enabled) -> PEND[0] at the 3rd edge, irq at the 4th.

Source files
------------

// File: rtl/p601_irq_pkg.sv
// p601_irq_pkg -- shared constants for the interrupt controller.
//   NUM_SRC     number of interrupt sources
//   ADDR_*      register offsets on the AD bus
//   VECT_NONE   VECT read value when no source is active
//   SRC_*       bit positions of the peripheral interrupt sources
package p601_irq_pkg;

  localparam int NUM_SRC = 8;

  localparam logic [2:0] ADDR_PEND = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd1;
  localparam logic [2:0] ADDR_EDGE = 3'd2;
  localparam logic [2:0] ADDR_VECT = 3'd3;
  localparam logic [2:0] ADDR_CTRL = 3'd4;
  localparam logic [2:0] ADDR_RAW  = 3'd5;

  localparam logic [7:0] VECT_NONE = 8'h80;

  localparam int SRC_VPU      = 0;
  localparam int SRC_SIMPLEIO = 1;
  localparam int SRC_UARTIO   = 2;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc -- 8-bit priority encoder, lowest index wins.
//   req    request vector
//   idx    index of the lowest set bit of req (0 when none set)
//   valid  1 when any bit of req is set
module irq_prio_enc
  import p601_irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [2:0]         idx,
  output logic               valid
);

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irqctrl.sv
// irqctrl -- 8-source interrupt controller with per-source level/edge mode,
// mask, global enable and a priority vector register.
//   clk   system clock (CPU clock), rising edge
//   rst   asynchronous reset, active low
//   src   peripheral interrupt requests, active high
//   AD    register select; DI write data; DO combinational read data
//   rw    1 = read, 0 = write; cs block select (VMA-qualified)
//   irq   registered interrupt request to the CPU
// Build option: define IRQCTRL_SYNC_EN to pass src through a 2-flop
// synchroniser (src->PEND 3 edges, src->irq 4); otherwise src is used
// directly (src->PEND 1 edge, src->irq 2).
module irqctrl
  import p601_irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [2:0]         AD,
  input  logic [7:0]         DI,
  output logic [7:0]         DO,
  input  logic               rw,
  input  logic               cs,
  output logic               irq
);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] edge_mode;
  logic               gie;

  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] mode_chg;
  logic               wr;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_edge;
  logic               wr_ctrl;
  logic [2:0]         vect_idx;
  logic               vect_valid;

`ifdef IRQCTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = src;
`endif

  assign wr      = cs && !rw;
  assign wr_pend = wr && (AD == ADDR_PEND);
  assign wr_mask = wr && (AD == ADDR_MASK);
  assign wr_edge = wr && (AD == ADDR_EDGE);
  assign wr_ctrl = wr && (AD == ADDR_CTRL);

  assign rise     = src_s & ~src_d;
  assign w1c      = wr_pend ? DI : '0;
  assign mode_chg = wr_edge ? (DI ^ edge_mode) : '0;

  // Edge bits: a rise in the same cycle as a W1C keeps the bit set.
  // Level bits follow src_s. Bits whose mode is being changed start clean.
  assign pend_nxt = ((edge_mode & (rise | (pend & ~w1c))) | (~edge_mode & src_s))
                    & ~mode_chg;

  assign act = pend & mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_d     <= '0;
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '0;
      gie       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      src_d <= src_s;
      pend  <= pend_nxt;
      irq   <= gie && (|act);
      if (wr_mask) mask      <= DI;
      if (wr_edge) edge_mode <= DI;
      if (wr_ctrl) gie       <= DI[0];
    end
  end

  irq_prio_enc u_prio (
    .req   (act),
    .idx   (vect_idx),
    .valid (vect_valid)
  );

  always_comb begin
    DO = 8'h00;
    case (AD)
      ADDR_PEND: DO = pend;
      ADDR_MASK: DO = mask;
      ADDR_EDGE: DO = edge_mode;
      ADDR_VECT: DO = vect_valid ? {5'b0, vect_idx} : VECT_NONE;
      ADDR_CTRL: DO = {7'b0, gie};
      ADDR_RAW:  DO = src_s;
      default:   DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irqctrl.sv
// tb_irqctrl -- self-checking bench for irqctrl: directed scenarios plus
// randomized register traffic and source activity, compared against a
// behavioural model of the register rules. Define IRQCTRL_SYNC_EN for
// both RTL and bench to exercise the synchronised build.
module tb_irqctrl;

`ifdef IRQCTRL_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] src;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;

  int n_total;
  int n_bad;

  // behavioural model state
  logic [7:0] m_pend, m_mask, m_edge, m_srcd, m_s1, m_s2, m_src;
  logic       m_gie, m_irq;
  logic [7:0] rd_val [8];

  string reg_name [8] = '{"pend", "mask", "edge", "vect", "ctrl", "raw", "ad6", "ad7"};

  irqctrl dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .AD  (AD),
    .DI  (DI),
    .DO  (DO),
    .rw  (rw),
    .cs  (cs),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_src_s();
`ifdef IRQCTRL_SYNC_EN
    return m_s2;
`else
    return m_src;
`endif
  endfunction

  function automatic logic [7:0] exp_reg(input int a);
    logic [7:0] act;
    logic [7:0] v;
    act = m_pend & m_mask;
    case (a)
      0: return m_pend;
      1: return m_mask;
      2: return m_edge;
      3: begin
        v = 8'h80;
        for (int i = 0; i < 8; i++) begin
          if (act[i]) begin
            v = 8'(i);
            break;
          end
        end
        return v;
      end
      4: return {7'b0, m_gie};
      5: return model_src_s();
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_edge = 0; m_srcd = 0;
    m_s1 = 0; m_s2 = 0; m_gie = 0; m_irq = 0;
  endtask

  task automatic read_all(input string pfx);
    for (int a = 0; a < 8; a++) begin
      AD = 3'(a);
      #1;
      rd_val[a] = DO;
      check_val({pfx, reg_name[a]}, DO, exp_reg(a));
    end
  endtask

  // One clock cycle: drive the bus/sources, predict, then read back
  // every register between the rising edge and the next falling edge.
  task automatic step(input logic i_cs, input logic i_rw, input logic [2:0] i_ad,
                      input logic [7:0] i_di, input logic [7:0] i_src);
    logic [7:0] s_now, n_pend, chg;
    logic       wr, n_irq;
    cs = i_cs; rw = i_rw; AD = i_ad; DI = i_di; src = i_src;
    m_src = i_src;
    s_now = model_src_s();
    wr    = i_cs && !i_rw;
    chg   = (wr && i_ad == 3'd2) ? (i_di ^ m_edge) : 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (chg[i])
        n_pend[i] = 1'b0;
      else if (m_edge[i])
        n_pend[i] = (s_now[i] && !m_srcd[i]) ||
                    (m_pend[i] && !(wr && i_ad == 3'd0 && i_di[i]));
      else
        n_pend[i] = s_now[i];
    end
    n_irq = m_gie && ((m_pend & m_mask) != 8'h00);
    @(posedge clk);
    #1;
    m_pend = n_pend;
    m_srcd = s_now;
    m_irq  = n_irq;
    if (wr) begin
      case (i_ad)
        3'd1: m_mask = i_di;
        3'd2: m_edge = i_di;
        3'd4: m_gie  = i_di[0];
        default: ;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = i_src;
    cs = 1'b0; rw = 1'b1;
    check_val("irq", {7'b0, irq}, {7'b0, m_irq});
    read_all("rd_");
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d, input logic [7:0] s);
    step(1'b1, 1'b0, a, d, s);
  endtask

  task automatic idle(input logic [7:0] s);
    step(1'b0, 1'b1, 3'd0, 8'h00, s);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b0; src = 8'h00; AD = 3'd0; DI = 8'h00; rw = 1'b1; cs = 1'b0;
    model_reset();
    m_src = 8'h00;
    #3;
    check_val("rst_irq", {7'b0, irq}, 8'h00);
    read_all("rst_");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // level-mode source 1: irq follows src with the pipeline latency
    wr_reg(3'd1, 8'h02, 8'h00);
    wr_reg(3'd4, 8'h01, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      idle(8'h02);
      check_val("lvl_rise_irq", {7'b0, irq}, {7'b0, k >= 2 + SLAT});
    end
    check_val("lvl_vect", rd_val[3], 8'h01);
    for (int k = 1; k <= 2 + SLAT; k++) begin
      idle(8'h00);
      check_val("lvl_fall_irq", {7'b0, irq}, {7'b0, k < 2 + SLAT});
    end

    // edge-mode source 2: single pulse latches, W1C clears
    wr_reg(3'd2, 8'h04, 8'h00);
    wr_reg(3'd1, 8'h04, 8'h00);
    idle(8'h04);
    for (int k = 0; k < SLAT + 3; k++) idle(8'h00);
    check_val("edge_pend_held", rd_val[0], 8'h04);
    check_val("edge_irq_held", {7'b0, irq}, 8'h01);
    wr_reg(3'd0, 8'h04, 8'h00);
    check_val("edge_w1c_pend", rd_val[0], 8'h00);
    idle(8'h00);
    check_val("edge_w1c_irq", {7'b0, irq}, 8'h00);

    // rise and W1C in the same cycle: set wins
    for (int k = 0; k < SLAT; k++) idle(8'h04);
    wr_reg(3'd0, 8'h04, 8'h04);
    check_val("set_wins", rd_val[0], 8'h04);
    wr_reg(3'd0, 8'h04, 8'h04);
    check_val("w1c_after", rd_val[0], 8'h00);

    // priority vector
    wr_reg(3'd2, 8'h00, 8'h00);
    wr_reg(3'd1, 8'h0A, 8'h00);
    for (int k = 0; k <= SLAT; k++) idle(8'h0A);
    check_val("vect_0a", rd_val[3], 8'h01);
    for (int k = 0; k <= SLAT; k++) idle(8'h08);
    check_val("vect_08", rd_val[3], 8'h03);
    for (int k = 0; k <= SLAT; k++) idle(8'h00);
    check_val("vect_none", rd_val[3], 8'h80);

    // asynchronous reset with everything pending
    wr_reg(3'd1, 8'hFF, 8'hFF);
    for (int k = 0; k < SLAT + 3; k++) idle(8'hFF);
    check_val("pre_rst_pend", rd_val[0], 8'hFF);
    check_val("pre_rst_irq", {7'b0, irq}, 8'h01);
    #2;
    rst = 1'b0;
    src = 8'h00;
    model_reset();
    m_src = 8'h00;
    #1;
    check_val("async_rst_irq", {7'b0, irq}, 8'h00);
    read_all("arst_");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    begin
      logic [7:0] s_cur;
      logic [2:0] a;
      s_cur = 8'h00;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 3) == 0) s_cur = 8'($urandom);
        a = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1)
          step(1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom), s_cur);
        else
          idle(s_cur);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
